// File: rtl/pwm_multi_channel.sv
// N-channel PWM with one shared period counter, edge/center alignment and a
// shadow config that is only committed at period boundaries or on start.
module pwm_multi_channel #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    EN_I,
  input  logic                    LOAD_I,
  input  logic [CNT_W-1:0]        PERIOD_I,
  input  logic                    MODE_I,
  input  logic [NUM_CH*CNT_W-1:0] DUTY_CYCLE_I,
  output logic                    BUSY_O,
  output logic                    PEND_O,
  output logic                    PERIOD_DONE_O,
  output logic [NUM_CH-1:0]       PWM_OUT_O
);
  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_RUN  = 2'd1;
  localparam logic [1:0]       S_STOP = 2'd2;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0]             per;
    logic                         mode;
    logic [NUM_CH-1:0][CNT_W-1:0] duty;
  } cfg_t;

  cfg_t             act_q, shd_q, cfg_in;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_eff;
  logic             dn_q, dn_d, pend_q, done_q;
  logic             busy, bnd, apply;
  logic [NUM_CH-1:0] pwm_d, pwm_q;

  assign cfg_in = {PERIOD_I, MODE_I, DUTY_CYCLE_I};

  // Center mode treats P=0 as P=1; with P=1 there is no down leg, so the
  // boundary is simply the top of the count.
  always_comb begin
    busy    = (state_q != S_IDLE);
    per_eff = (act_q.mode && act_q.per == '0) ? ONE : act_q.per;
    if (!act_q.mode)         bnd = (cnt_q == act_q.per);
    else if (per_eff == ONE) bnd = (cnt_q == ONE);
    else                     bnd = dn_q && (cnt_q == ONE);
    apply = (state_q == S_IDLE && EN_I) || (busy && bnd);
  end

  always_comb begin
    cnt_d = cnt_q;
    dn_d  = dn_q;
    if (!busy || bnd) begin
      cnt_d = '0;
      dn_d  = 1'b0;
    end else if (act_q.mode && (dn_q || cnt_q == per_eff)) begin
      cnt_d = cnt_q - ONE;
      dn_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (EN_I) state_d = S_RUN;
      S_RUN:   if (!EN_I) state_d = S_STOP;
      S_STOP:  if (EN_I) state_d = S_RUN;
               else if (bnd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = busy && (cnt_q < act_q.duty[i]);
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dn_q    <= 1'b0;
      done_q  <= 1'b0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dn_q    <= dn_d;
      done_q  <= busy && bnd;
      pwm_q   <= pwm_d;
    end
  end

  // A load landing on an apply cycle bypasses the shadow and never raises pend.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      act_q.per  <= '1;
      act_q.mode <= 1'b0;
      act_q.duty <= '0;
      shd_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (LOAD_I) shd_q <= cfg_in;
      if (apply) begin
        if (LOAD_I)      act_q <= cfg_in;
        else if (pend_q) act_q <= shd_q;
        pend_q <= 1'b0;
      end else if (LOAD_I) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign BUSY_O        = busy;
  assign PEND_O        = pend_q;
  assign PERIOD_DONE_O = done_q;
  assign PWM_OUT_O     = pwm_q;
endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised N-channel PWM generator sharing one period counter. It supports edge-aligned and center-aligned modes, a programmable period and a per-channel duty cycle. Configuration is double-buffered: values written with LOAD_I take effect only at a period boundary, so outputs never glitch. It sits between a register/control block and the PWM output pins, and generalises the single-channel, fixed-8-bit-period PWM generator.

Parameters:
NUM_CH, 4, number of PWM channels (1..16)
CNT_W, 8, counter/period/duty width in bits (4..16)

Ports:
CLK_I  in  1  system clock, all logic on rising edge
RST_I  in  1  asynchronous, active-high reset
EN_I  in  1  run request (level)
LOAD_I  in  1  single-cycle strobe; capture PERIOD_I, MODE_I, DUTY_CYCLE_I into shadow regs
PERIOD_I  in  CNT_W  period value P
MODE_I  in  1  0 = edge-aligned, 1 = center-aligned
DUTY_CYCLE_I  in  NUM_CH*CNT_W  channel i duty in bits [i*CNT_W +: CNT_W]
BUSY_O  out  1  high in RUN and STOP states
PEND_O  out  1  shadow config captured, not yet applied
PERIOD_DONE_O  out  1  one-cycle pulse at each period end
PWM_OUT_O  out  NUM_CH  PWM outputs, registered

Behaviour:
- Reset (async, immediate, including mid-operation): state IDLE, counter 0, direction up, all outputs 0, shadow regs cleared. Active config resets to P = 2^CNT_W-1, mode edge, all duties 0.
- Shadow load: LOAD_I=1 captures the inputs into shadow regs and sets PEND_O=1. A second LOAD before apply overwrites the shadow regs.
- Apply: at a period boundary, or on the IDLE->RUN transition, when PEND_O=1: shadow -> active, PEND_O -> 0.
- LOAD_I coincident with a boundary or start cycle: the inputs presented that cycle go directly to active, and PEND_O stays 0.
- FSM:
  - IDLE: counter held at 0. EN_I=1 -> RUN, counter starts at 0 on the next cycle.
  - RUN: counts. EN_I=0 -> STOP.
  - STOP: counts until the period boundary, then -> IDLE. EN_I=1 during STOP -> RUN with no break in the counter sequence.
- Edge mode:
  - Counter sequence 0,1,..,P, then wraps to 0. Period = P+1 cycles.
  - Boundary = cycle where counter == P.
  - P=0 gives a 1-cycle period.
- Center mode:
  - Counter sequence up 0..P, then down P-1..1, then 0. Period = 2P cycles.
  - Boundary = cycle where counter == 1 while counting down (or counter == P when P=1).
  - An active P of 0 behaves as P=1.
  - A mode change at a boundary restarts the counter at 0, counting up.
- Compare: channel i is high iff counter < duty_i, evaluated on unsigned CNT_W values.
  - duty=0 -> constantly low.
  - Edge mode, duty > P -> constantly high.
  - Center mode, duty > P -> constantly high.
- Latency:
  - PWM_OUT_O and PERIOD_DONE_O are registered. The value for counter==k appears in the cycle after counter==k.
  - PERIOD_DONE_O pulses for exactly 1 cycle per period, including the final period before STOP->IDLE.
- IDLE: PWM_OUT_O=0 and PERIOD_DONE_O=0. On the cycle after returning to IDLE, outputs are forced 0.
- Changing EN_I has no effect on shadow or active config.

Test Plan:
1. Assert RST_I mid-run with EN_I=1 -> all outputs 0 in the same cycle, without waiting for a clock edge. After release with EN_I=0 -> BUSY_O=0, PEND_O=0.
2. Edge mode: LOAD P=9, duties {0,3,10,255}, then EN_I=1 -> ch0 always 0, ch1 high 3 of every 10 cycles, ch2 and ch3 always 1. PERIOD_DONE_O pulses every 10 cycles, and PEND_O clears at start.
3. Center mode: P=4, ch1 duty=2 -> period 8 cycles, PERIOD_DONE_O every 8 cycles. ch1 high 3 consecutive cycles, centered on counter==0 (counter values 1,0,1 across the wrap).
4. Edge mode, P=9, ch1 duty 3: LOAD duty=7 at counter==4 -> PEND_O=1, and the current period keeps 3 high cycles. The next period has 7 high cycles and PEND_O drops at the boundary. A LOAD exactly at counter==9 applies directly with PEND_O staying 0.
5. EN_I=0 at counter==2 (P=9) -> the period completes. The final PERIOD_DONE_O pulse fires, then BUSY_O falls and PWM_OUT_O=0. A separate run re-asserts EN_I at counter==6 in STOP -> counter continues 7,8,9,0 and BUSY_O never drops.
6. Parameter sweep NUM_CH=1, CNT_W=4 with P=15, duty=15 -> high 15 of 16 cycles. Duty 16 is not representable, so verify duty=0 is constantly low.
